// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM state type and alignment helper shared by the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } lsu_state_t;
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane extract/extend (word,off,size,uns -> ext) and sub-word merge (word,data,off,size -> merged)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] data,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  logic [31:0] lane;
  logic [31:0] mask;
  always_comb begin
    lane = word >> {off, 3'b000};
    ext = size == SZ_BYTE ? {{24{~uns & lane[7]}}, lane[7:0]}
        : size == SZ_HALF ? {{16{~uns & lane[15]}}, lane[15:0]}
        : word;
    mask = (size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << {off, 3'b000};
    merged = (word & ~mask) | ((data << {off, 3'b000}) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage FSM; pipeline side (req/we/size/unsigned/addr/wdata -> rdata/done/err/stall), memory side (mem_addr/wdata/read/write, mem_rdata)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_rdata_i
);
  lsu_state_t state, next;
  logic we_q, uns_q, err_q, bad, accept;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, merge_q, ext, merged;
  assign accept = state == S_IDLE && req_i;
  assign bad = size_i == 2'b11 || lsu_misaligned(size_i, addr_i[1:0]);
  lsu_lane_align u_align (
    .word  (state == S_LOAD ? mem_rdata_i : merge_q),
    .off   (addr_q[1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .data  (wdata_q),
    .ext   (ext),
    .merged(merged)
  );
  always_comb
    next = state == S_IDLE ? (!req_i ? S_IDLE : bad ? S_DONE : !we_i ? S_LOAD : size_i == SZ_WORD ? S_STORE : S_RMW_RD)
         : state == S_RMW_RD ? S_RMW_WR
         : state == S_DONE ? S_IDLE
         : S_DONE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_o <= '0;
    end else begin
      state <= next;
      if (accept) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        err_q   <= bad;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state == S_RMW_RD) merge_q <= mem_rdata_i;
      if (state == S_LOAD) rdata_o <= ext;
    end
  assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_read_o  = state == S_LOAD || state == S_RMW_RD;
  assign mem_write_o = state == S_STORE || state == S_RMW_WR;
  assign mem_wdata_o = state == S_STORE ? wdata_q : state == S_RMW_WR ? merged : '0;
  assign done_o      = state == S_DONE;
  assign err_o       = state == S_DONE && err_q;
  assign stall_o     = accept || (state != S_IDLE && state != S_DONE);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit against a word-ported memory model
module tb_load_store_unit;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  mi;
    logic [31:0] mw;
  } vec_t;
  logic clk = 0, rst = 1, req = 0, we = 0, uns = 0, boot = 1;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, mem_addr, mem_wdata, mem_rdata;
  logic done, err, stall, mem_read, mem_write;
  logic [31:0] mem [16];
  int checks = 0, failures = 0, cyc = 0, wr_count = 0;
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .err_o(err), .stall_o(stall),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata)
  );
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (boot) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0123_4567;
      mem[2] <= 32'h8899_AABB;
    end else if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string tag, output int dc);
    int stalls = 0;
    logic rd = 0, wr = 0, got = 0;
    we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata; req = 1;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      if (done && stalls > 0) got = 1;
      else begin
        stalls += int'(stall);
        rd |= mem_read;
        wr |= mem_write;
        @(negedge clk);
      end
    end
    dc = cyc;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, stalls, v.lat);
    chk({tag, " err"}, 32'(err), 32'(v.err));
    chk({tag, " rdata"}, rdata, v.rdata);
    chk({tag, " mem_read_seen"}, 32'(rd), 32'(!v.err && (!v.we || v.size != 2'b10)));
    chk({tag, " mem_write_seen"}, 32'(wr), 32'(!v.err && v.we));
    chk({tag, " mem_word"}, mem[v.mi], v.mw);
  endtask
  vec_t tbl [13];
  initial begin
    int d1, d2, wr_before;
    vec_t st, ld;
    tbl[0]  = '{0, 2'd0, 0, 32'h9, 32'h0,         32'hFFFF_FFAA, 0, 2, 4'd2, 32'h8899_AABB};
    tbl[1]  = '{0, 2'd0, 1, 32'h9, 32'h0,         32'h0000_00AA, 0, 2, 4'd2, 32'h8899_AABB};
    tbl[2]  = '{0, 2'd1, 0, 32'hA, 32'h0,         32'hFFFF_8899, 0, 2, 4'd2, 32'h8899_AABB};
    tbl[3]  = '{0, 2'd1, 1, 32'hA, 32'h0,         32'h0000_8899, 0, 2, 4'd2, 32'h8899_AABB};
    tbl[4]  = '{1, 2'd0, 0, 32'hA, 32'hFFFF_FF11, 32'h0000_8899, 0, 3, 4'd2, 32'h8811_AABB};
    tbl[5]  = '{0, 2'd2, 1, 32'h8, 32'h0,         32'h8811_AABB, 0, 2, 4'd2, 32'h8811_AABB};
    tbl[6]  = '{1, 2'd1, 0, 32'h8, 32'h1234_CAFE, 32'h8811_AABB, 0, 3, 4'd2, 32'h8811_CAFE};
    tbl[7]  = '{0, 2'd0, 0, 32'hB, 32'h0,         32'hFFFF_FF88, 0, 2, 4'd2, 32'h8811_CAFE};
    tbl[8]  = '{0, 2'd1, 0, 32'h3, 32'h0,         32'hFFFF_FF88, 1, 1, 4'd0, 32'h0000_0000};
    tbl[9]  = '{1, 2'd2, 0, 32'h6, 32'hAAAA_AAAA, 32'hFFFF_FF88, 1, 1, 4'd1, 32'h0123_4567};
    tbl[10] = '{0, 2'd3, 0, 32'h0, 32'h0,         32'hFFFF_FF88, 1, 1, 4'd0, 32'h0000_0000};
    tbl[11] = '{0, 2'd0, 0, 32'h8, 32'h0,         32'hFFFF_FFFE, 0, 2, 4'd2, 32'h8811_CAFE};
    tbl[12] = '{0, 2'd0, 1, 32'hB, 32'h0,         32'h0000_0088, 0, 2, 4'd2, 32'h8811_CAFE};
    repeat (2) @(negedge clk);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst mem_read", 32'(mem_read), 0);
    chk("rst mem_write", 32'(mem_write), 0);
    chk("rst rdata", rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    boot = 0;
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      run(tbl[i], $sformatf("vec%0d", i), d1);
      req = 0;
      @(negedge clk);
    end
    st = '{1, 2'd2, 0, 32'h4, 32'hDEAD_BEEF, 32'h0000_0088, 0, 2, 4'd1, 32'hDEAD_BEEF};
    ld = '{0, 2'd2, 1, 32'h4, 32'h0,         32'hDEAD_BEEF, 0, 2, 4'd1, 32'hDEAD_BEEF};
    run(st, "b2b_store", d1);
    run(ld, "b2b_load", d2);
    chk("b2b done spacing", d2 - d1, 3);
    req = 0;
    @(negedge clk);
    wr_before = wr_count;
    we = 1; size = 2'd0; uns = 0; addr = 32'h9; wdata = 32'h55; req = 1;
    @(posedge clk);
    #2;
    chk("rmw_rd mem_read", 32'(mem_read), 1);
    rst = 1;
    req = 0;
    #1;
    chk("midrst done", 32'(done), 0);
    chk("midrst err", 32'(err), 0);
    chk("midrst stall", 32'(stall), 0);
    chk("midrst mem_read", 32'(mem_read), 0);
    chk("midrst mem_write", 32'(mem_write), 0);
    chk("midrst rdata", rdata, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("midrst no write", wr_count, wr_before);
    chk("midrst mem unchanged", mem[2], 32'h8811_CAFE);
    run('{0, 2'd0, 1, 32'h9, 32'h0, 32'h0000_00CA, 0, 2, 4'd2, 32'h8811_CAFE}, "post_rst", d1);
    req = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
